fifo_rd_packer: RTL and testbench

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_pack_pkg.sv | 6 +
 rtl/fifo_pack_accum.sv | 32 +++
 rtl/fifo_rd_packer.sv | 87 ++++++++
 tb/tb_fifo_rd_packer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pack_pkg.sv
// fifo_pack_pkg: shared state encoding and default sizing for the FIFO read packer
package fifo_pack_pkg;
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_PACK_RATIO = 4;
  typedef enum logic [1:0] {FILL, FLUSH_WAIT, FLUSH_EMIT} pack_state_t;
endpackage

// File: rtl/fifo_pack_accum.sv
// fifo_pack_accum: lane accumulator with fill count and valid-lane mask
module fifo_pack_accum
  import fifo_pack_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK_RATIO = DEF_PACK_RATIO,
  parameter int CNT_WIDTH  = $clog2(PACK_RATIO + 1)
) (
  input  logic                                 rd_clk,
  input  logic                                 rd_rst,
  input  logic                                 cap_en,
  input  logic [DATA_WIDTH-1:0]                cap_data,
  input  logic                                 clr,
  output logic [CNT_WIDTH-1:0]                 acc_cnt,
  output logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lanes,
  output logic [PACK_RATIO-1:0]                keep
);
  always_comb begin
    keep = '0;
    for (int i = 0; i < PACK_RATIO; i++) keep[i] = CNT_WIDTH'(i) < acc_cnt;
  end
  // lanes are zeroed on every transfer so a partial word carries zero padding
  always_ff @(posedge rd_clk) begin
    if (rd_rst || clr) begin
      acc_cnt <= '0;
      lanes   <= '0;
    end else if (cap_en) begin
      for (int i = 0; i < PACK_RATIO; i++) if (acc_cnt == CNT_WIDTH'(i)) lanes[i] <= cap_data;
      acc_cnt <= acc_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains an async FIFO read port and packs PACK_RATIO entries per output word,
// with a flush path that emits a partial word marked by out_last.
module fifo_rd_packer
  import fifo_pack_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK_RATIO = DEF_PACK_RATIO,
  localparam int OUT_WIDTH = DATA_WIDTH * PACK_RATIO,
  localparam int CNT_WIDTH = $clog2(PACK_RATIO + 1)
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [PACK_RATIO-1:0] out_keep,
  output logic                  out_last,
  output logic                  flush_done
);
  pack_state_t                          state;
  logic                                 rd_pending;
  logic [CNT_WIDTH-1:0]                 acc_cnt;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lanes;
  logic [PACK_RATIO-1:0]                keep;
  logic                                 out_free, xfer_full, xfer_part, xfer;

  fifo_pack_accum #(
    .DATA_WIDTH(DATA_WIDTH),
    .PACK_RATIO(PACK_RATIO),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_accum (
    .rd_clk  (rd_clk),
    .rd_rst  (rd_rst),
    .cap_en  (rd_pending),
    .cap_data(fifo_rd_data),
    .clr     (xfer),
    .acc_cnt (acc_cnt),
    .lanes   (lanes),
    .keep    (keep)
  );

  // the in-flight read reserves a lane so the accumulator can never overflow
  always_comb begin
    out_free   = !out_valid || out_ready;
    xfer_full  = acc_cnt == CNT_WIDTH'(PACK_RATIO) && out_free && state != FLUSH_EMIT;
    xfer_part  = state == FLUSH_EMIT && acc_cnt != '0 && out_free;
    xfer       = xfer_full || xfer_part;
    fifo_rd_en = !rd_rst && !fifo_empty && state == FILL && !flush &&
                 ({1'b0, acc_cnt} + {{CNT_WIDTH{1'b0}}, rd_pending}) < (CNT_WIDTH + 1)'(PACK_RATIO);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state      <= FILL;
      rd_pending <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      rd_pending <= fifo_rd_en;
      flush_done <= 1'b0;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= lanes;
        out_keep  <= keep;
        out_last  <= xfer_part;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      unique case (state)
        FILL:       if (flush) state <= FLUSH_WAIT;
        FLUSH_WAIT: if (!rd_pending) state <= FLUSH_EMIT;
        FLUSH_EMIT: if (acc_cnt == '0 || out_free) begin
          state      <= FILL;
          flush_done <= 1'b1;
        end
        default:    state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: scenario tests against a queue-based FIFO and word packing model
module tb_fifo_rd_packer;
  logic        rd_clk = 1'b0, rd_rst = 1'b1, fifo_empty = 1'b1, flush = 1'b0, out_ready = 1'b1;
  logic [3:0]  fifo_rd_data = '0;
  logic        fifo_rd_en, out_valid, out_last, flush_done;
  logic [15:0] out_data;
  logic [3:0]  out_keep;

  typedef struct packed {logic [15:0] d; logic [3:0] k; logic l;} word_t;

  logic [3:0] q[$];
  word_t      rx[$];
  int         total = 0, bad = 0, n_reads = 0;

  fifo_rd_packer dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_keep    (out_keep),
    .out_last    (out_last),
    .flush_done  (flush_done)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO read side: data appears the cycle after an accepted read; consumer log of accepted words
  always @(posedge rd_clk) begin
    if (fifo_rd_en && !fifo_empty && q.size() > 0) begin
      fifo_rd_data <= q.pop_front();
      n_reads++;
    end
    if (out_valid && out_ready) rx.push_back('{d: out_data, k: out_keep, l: out_last});
  end

  always @(negedge rd_clk) fifo_empty = (q.size() == 0);

  task automatic push(input logic [3:0] v);
    q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  function automatic word_t pack4(input logic [3:0] a, b, c, d);
    return '{d: {d, c, b, a}, k: 4'hF, l: 1'b0};
  endfunction

  task automatic wait_rx(input int n, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge rd_clk);
      ok = rx.size() >= n;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s timeout: words got %0d want %0d", name, rx.size(), n);
    end
  endtask

  task automatic do_reset;
    @(negedge rd_clk);
    rd_rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    q.delete();
    fifo_empty = 1'b1;
    repeat (2) @(negedge rd_clk);
    rd_rst = 1'b0;
    rx.delete();
  endtask

  task automatic test_reset;
    @(negedge rd_clk);
    rd_rst = 1'b1;
    push(4'h9);
    push(4'h3);
    @(negedge rd_clk);
    #1;
    total++;
    if (fifo_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_rd_en got %b want 0", fifo_rd_en);
    end
    total++;
    if ({out_valid, out_data, out_keep, out_last, flush_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b d=%h k=%h l=%b fd=%b want all 0",
               out_valid, out_data, out_keep, out_last, flush_done);
    end
    do_reset();
  endtask

  task automatic test_full_words;
    bit ok;
    word_t e;
    do_reset();
    @(negedge rd_clk);
    for (int i = 1; i <= 8; i++) push(4'(i));
    wait_rx(2, "full_words", ok);
    if (ok) for (int w = 0; w < 2; w++) begin
      e = w == 0 ? pack4(4'h1, 4'h2, 4'h3, 4'h4) : pack4(4'h5, 4'h6, 4'h7, 4'h8);
      total++;
      if (rx[w] !== e) begin
        bad++;
        $display("FAIL full_word%0d got %h want %h", w, rx[w], e);
      end
    end
  endtask

  task automatic test_flush_partial;
    bit seen = 1'b0, fd = 1'b0, emp = 1'b0;
    word_t got = '0, e;
    do_reset();
    @(negedge rd_clk);
    push(4'hA);
    push(4'hB);
    push(4'hC);
    repeat (10) @(negedge rd_clk);
    flush = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge rd_clk);
      flush = 1'b0;
      #1;
      if (out_valid) begin
        seen = 1'b1;
        got = '{d: out_data, k: out_keep, l: out_last};
        fd = flush_done;
        emp = fifo_empty;
      end
    end
    e = '{d: 16'h0CBA, k: 4'h7, l: 1'b1};
    total++;
    if (!seen || got !== e) begin
      bad++;
      $display("FAIL flush_partial_word seen=%b got %h want %h", seen, got, e);
    end
    total++;
    if (fd !== 1'b1 || emp !== 1'b1) begin
      bad++;
      $display("FAIL flush_partial_done got fd=%b empty=%b want fd=1 empty=1", fd, emp);
    end
  endtask

  task automatic test_flush_empty;
    bit ok;
    logic [3:0] v[4];
    word_t e;
    do_reset();
    @(negedge rd_clk);
    flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v[i] = 4'($urandom_range(0, 15));
      push(v[i]);
    end
    #1;
    total++;
    if (fifo_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL flush_empty_rd_en_c0 got %b want 0", fifo_rd_en);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge rd_clk);
      flush = 1'b0;
      #1;
      total++;
      if ((k < 3 && {fifo_rd_en, flush_done, out_valid} !== 3'b000) ||
          (k == 3 && {flush_done, out_valid} !== 2'b10)) begin
        bad++;
        $display("FAIL flush_empty_c%0d got rd_en=%b fd=%b v=%b want fd=%0d others 0",
                 k, fifo_rd_en, flush_done, out_valid, k == 3);
      end
    end
    wait_rx(1, "flush_empty_resume", ok);
    e = pack4(v[0], v[1], v[2], v[3]);
    total++;
    if (ok && rx[0] !== e) begin
      bad++;
      $display("FAIL flush_empty_resume got %h want %h", rx[0], e);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    word_t e;
    do_reset();
    @(negedge rd_clk);
    out_ready = 1'b0;
    n_reads = 0;
    for (int i = 1; i <= 12; i++) push(4'(i));
    repeat (40) begin
      @(negedge rd_clk);
      #1;
      if (out_valid) begin
        total++;
        if (out_data !== 16'h4321 || out_keep !== 4'hF || out_last !== 1'b0) begin
          bad++;
          $display("FAIL held_word got %h/%h/%b want 4321/f/0", out_data, out_keep, out_last);
        end
      end
    end
    total++;
    if (n_reads != 8 || fifo_rd_en !== 1'b0 || !out_valid) begin
      bad++;
      $display("FAIL backpressure_reads got %0d rd_en=%b v=%b want 8 rd_en=0 v=1",
               n_reads, fifo_rd_en, out_valid);
    end
    out_ready = 1'b1;
    wait_rx(3, "backpressure_drain", ok);
    if (ok) for (int w = 0; w < 3; w++) begin
      e = pack4(4'(4 * w + 1), 4'(4 * w + 2), 4'(4 * w + 3), 4'(4 * w + 4));
      total++;
      if (rx[w] !== e) begin
        bad++;
        $display("FAIL drain_word%0d got %h want %h", w, rx[w], e);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    word_t e;
    do_reset();
    @(negedge rd_clk);
    for (int i = 1; i <= 5; i++) push(4'(i));
    @(negedge rd_clk);
    rd_rst = 1'b1;
    @(negedge rd_clk);
    #1;
    total++;
    if ({fifo_rd_en, out_valid, out_data, out_keep, out_last, flush_done} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs got rd_en=%b v=%b d=%h k=%h l=%b fd=%b want all 0",
               fifo_rd_en, out_valid, out_data, out_keep, out_last, flush_done);
    end
    rd_rst = 1'b0;
    wait_rx(1, "reset_mid_word", ok);
    e = pack4(4'h2, 4'h3, 4'h4, 4'h5);
    total++;
    if (ok && rx[0] !== e) begin
      bad++;
      $display("FAIL reset_mid_word got %h want %h", rx[0], e);
    end
  endtask

  task automatic test_random_stream;
    localparam int N = 202;
    logic [3:0] sent[$];
    int cyc = 0, n;
    bit ok;
    word_t e;
    do_reset();
    while ((sent.size() < N || q.size() != 0 || rx.size() < N / 4) && cyc < 4000) begin
      @(negedge rd_clk);
      cyc++;
      out_ready = $urandom_range(0, 3) != 0;
      if (sent.size() < N && $urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n && sent.size() < N; i++) begin
          sent.push_back(4'($urandom_range(0, 15)));
          push(sent[sent.size() - 1]);
        end
      end
      #1;
      total++;
      if (fifo_rd_en && fifo_empty) begin
        bad++;
        $display("FAIL rd_en_while_empty cycle %0d got rd_en=1 want 0", cyc);
      end
    end
    out_ready = 1'b1;
    repeat (4) @(negedge rd_clk);
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    wait_rx(N / 4 + 1, "random_stream", ok);
    repeat (4) @(negedge rd_clk);
    total++;
    if (rx.size() != N / 4 + 1) begin
      bad++;
      $display("FAIL random_word_count got %0d want %0d", rx.size(), N / 4 + 1);
    end
    if (ok) for (int w = 0; w <= N / 4; w++) begin
      e = w < N / 4 ? pack4(sent[4 * w], sent[4 * w + 1], sent[4 * w + 2], sent[4 * w + 3])
                    : '{d: {8'h00, sent[4 * w + 1], sent[4 * w]}, k: 4'h3, l: 1'b1};
      total++;
      if (rx[w] !== e) begin
        bad++;
        $display("FAIL random_word%0d got %h want %h", w, rx[w], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_flush_partial();
    test_flush_empty();
    test_backpressure();
    test_reset_mid();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
